// File: rtl/common_types_pkg.sv
// Shared AHB-Lite bus types and the multi-channel controller state encoding.
package common_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HsizeByte = 3'b000,
        HsizeHalf = 3'b001,
        HsizeWord = 3'b010
    } hsize_t;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StErr2
    } amc_state_t;

    // Reserved size 11 is treated as misaligned so it completes locally with an error.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Picks one eligible channel per cycle: lowest index first, or round-robin from rr_ptr.
module ahb_rr_arbiter #(
    parameter int NCH = 2,
    parameter int RR  = 0
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic [NCH-1:0] eligible,
    input  logic           advance,
    output logic [NCH-1:0] winner
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] win_idx;

    always_comb begin
        int   start;
        int   idx;
        logic found;
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        start   = (RR != 0) ? int'(rr_ptr) : 0;
        for (int i = 0; i < NCH; i++) begin
            idx = start + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                win_idx     = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (win_idx == PW'(NCH - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_multi_controller.sv
// AHB-Lite manager arbitrating NCH request channels onto one bus, with local
// rejection of misaligned requests and two-cycle ERROR handling.
module ahb_multi_controller
    import common_types_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR     = 0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        write,
    input  logic [2*NCH-1:0]      size,
    input  logic [NCH*ADDR_W-1:0] addr,
    input  logic [NCH*DATA_W-1:0] wdata,
    output logic [NCH-1:0]        gnt,
    output logic [NCH-1:0]        done,
    output logic                  err,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     haddr,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [1:0]            htrans,
    output logic [DATA_W-1:0]     hwdata,
    input  logic [DATA_W-1:0]     hrdata,
    input  logic                  hready,
    input  logic                  hresp
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    amc_state_t        state_q;
    logic [IW-1:0]     owner_q, loc_idx_q, hold_idx_q, win_idx;
    logic              loc_q, hold_q;
    logic [DATA_W-1:0] hwdata_q;

    logic [NCH-1:0]    busy, eligible, arb_elig, win;
    logic [1:0]        win_size;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_write, have_win, win_mis, err1, present, accept, bus_acc, loc_acc;

    always_comb begin
        busy = '0;
        if (state_q != StIdle) busy[owner_q] = 1'b1;
        if (loc_q) busy[loc_idx_q] = 1'b1;
    end

    assign eligible = req & ~busy;

    // A stalled address phase keeps its channel so haddr/htrans stay stable.
    always_comb begin
        arb_elig = eligible;
        if (hold_q) begin
            arb_elig             = '0;
            arb_elig[hold_idx_q] = 1'b1;
        end
    end

    ahb_rr_arbiter #(
        .NCH (NCH),
        .RR  (RR)
    ) u_arb (
        .clk      (clk),
        .nrst     (nrst),
        .eligible (arb_elig),
        .advance  (accept),
        .winner   (win)
    );

    always_comb begin
        win_idx   = '0;
        win_size  = '0;
        win_addr  = '0;
        win_wdata = '0;
        win_write = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (win[i]) begin
                win_idx   = IW'(i);
                win_size  = size[2*i +: 2];
                win_addr  = addr[i*ADDR_W +: ADDR_W];
                win_wdata = wdata[i*DATA_W +: DATA_W];
                win_write = write[i];
            end
        end
    end

    assign have_win = |win;
    assign win_mis  = is_misaligned(win_size, win_addr[1:0]);
    assign err1     = (state_q == StData) && hresp && !hready;
    assign present  = have_win && !win_mis && !err1;
    assign accept   = have_win && hready;
    assign bus_acc  = accept && !win_mis;
    assign loc_acc  = accept && win_mis;

    assign htrans = present ? HtransNonseq : HtransIdle;
    assign haddr  = present ? win_addr : '0;
    assign hwrite = present && win_write;
    assign hsize  = present ? {1'b0, win_size} : 3'b000;
    assign gnt    = accept ? win : '0;
    assign hwdata = hwdata_q;
    assign rdata  = hrdata;

    // A local rejection is only granted when no bus transfer starts, so its
    // completion never collides with a bus completion.
    always_comb begin
        done = '0;
        err  = 1'b0;
        if (hready && state_q != StIdle) begin
            done[owner_q] = 1'b1;
            err           = hresp || (state_q == StErr2);
        end
        if (loc_q) begin
            done[loc_idx_q] = 1'b1;
            err             = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            loc_q      <= 1'b0;
            loc_idx_q  <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
            hwdata_q   <= '0;
        end else begin
            hold_q     <= present && !hready;
            hold_idx_q <= win_idx;
            loc_q      <= loc_acc;
            if (loc_acc) loc_idx_q <= win_idx;
            if (bus_acc) begin
                owner_q  <= win_idx;
                hwdata_q <= win_wdata;
            end
            unique case (state_q)
                StIdle: if (bus_acc) state_q <= StData;
                StData: begin
                    if (hready)     state_q <= bus_acc ? StData : StIdle;
                    else if (hresp) state_q <= StErr2;
                end
                StErr2: if (hready) state_q <= bus_acc ? StData : StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/ahb_multi_controller.md
# ahb_multi_controller

Parametrised AHB-Lite manager that arbitrates NCH independent request channels onto one AHB bus, replacing the fixed instruction/data two-port controller in front of `ahb_multiplexor`. It provides:
- fixed or round-robin priority;
- byte/half/word sizes;
- pipelined address/data phases;
- wait-state stalls;
- two-cycle ERROR responses;
- local rejection of misaligned requests.

## Interface
Parameters:
- NCH, 2, number of request channels (1..8); channel 0 is highest priority in fixed mode.
- ADDR_W, 32, address width.
- DATA_W, 32, data width (32 only supported for sizing; parameter kept for bus typedefs).
- RR, 0, arbitration mode: 0 fixed priority, 1 round-robin.

Ports:
- clk  in  1  system clock; all state on rising edge.
- nrst  in  1  asynchronous active-low reset.
- req  in  NCH  per-channel request; held high until gnt.
- write  in  NCH  1 = write, 0 = read.
- size  in  NCH×2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- addr  in  NCH×ADDR_W  byte address.
- wdata  in  NCH×DATA_W  write data; sampled in the gnt cycle.
- gnt  out  NCH  one-hot pulse: request accepted this cycle.
- done  out  NCH  one-hot pulse: transfer complete.
- err  out  1  valid with done; 1 = ERROR response or local misalignment.
- rdata  out  DATA_W  valid with done on reads; equals hrdata.
- haddr, hwrite, hsize[2:0], htrans[1:0], hwdata  out  AHB-Lite manager outputs.
- hrdata, hready, hresp  in  AHB-Lite returns from the multiplexor.

## Operation
- Eligible channels: req=1 and no transfer outstanding on that channel.
- Arbitration: combinational over eligible channels.
  - Fixed mode: lowest eligible index wins.
  - RR mode: search starts at rr_ptr and wraps modulo NCH; rr_ptr <= winner+1 (wraps) on every gnt.
- Address phase: driven combinationally from the winner.
  - Outputs: htrans=NONSEQ, haddr, hwrite, hsize={0,size}.
  - Accepted when hready=1: gnt[winner]=1; hwdata_q <= wdata; data phase is owned by that channel next cycle.
- Misalignment: half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - Bus side: no bus transfer; htrans=IDLE.
  - Handshake: gnt pulses, and in the next cycle done+err for that channel.
  - Arbitration: the local completion does not block other channels' arbitration in that next cycle.
- FSM states:
  - IDLE: no data phase.
  - DATA: data phase outstanding.
  - ERR2: second ERROR cycle.
- IDLE -> DATA on an accepted bus address phase.
- DATA, hready=1, hresp=0:
  - Completion: done[owner]=1, err=0, rdata=hrdata.
  - Pipelined transfer: a new address phase may be accepted in the same cycle; the FSM stays in DATA with the new owner, otherwise goes to IDLE.
- DATA, hready=0, hresp=0: wait state; all address-phase outputs held; no gnt.
- DATA, hready=0, hresp=1 (first error cycle):
  - htrans forced IDLE; no gnt; go to ERR2.
- ERR2, hready=1, hresp=1: done[owner]=1, err=1; new address phase allowed; the FSM goes to DATA or IDLE.
- hwdata = hwdata_q throughout the data phase.

## Timing
- Zero-wait read: req at cycle N (gnt at N) -> done and rdata at cycle N+1.
- Each hready=0 cycle adds one cycle to completion.
- Back-to-back throughput: one transfer per cycle while hready=1 and requests are eligible.
- Simultaneous events:
  - done of channel A and gnt of channel B may share a cycle.
  - A channel cannot be granted in its own done cycle; its next gnt is at the earliest the following cycle.
- Reset values: htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0, gnt=0, done=0, err=0, rdata=hrdata (passthrough), rr_ptr=0, state IDLE.
- Reset asserted mid-transfer abandons the transfer; no done is produced.

## Structure
- common_types_pkg (existing) gains: htrans_t (IDLE/BUSY/NONSEQ/SEQ), hsize_t, amc_state_t (IDLE/DATA/ERR2); word_t reused for data.
- Sub-module ahb_rr_arbiter:
  - Parameters: NCH, RR.
  - Inputs: eligible vector, advance.
  - Output: one-hot winner.
  - Internal: owns rr_ptr.
- Top level: holds the FSM, owner index, local-error flag, and hwdata_q.

## Test plan
- NCH=2, RR=0:
  - Write ch1 word 0x01234567 to 0x4, then read ch0 from 0x4 -> ch0 done at N+1 with rdata 0x01234567, err=0.
  - ch0 and ch1 both request reads every cycle -> ch0 granted whenever eligible; ch1 granted only in ch0's done cycles.
- NCH=4, RR=1, all four requesting continuously -> gnt order 0,1,2,3,0; rr_ptr wraps 3->0.
- Two hready=0 wait cycles during a read data phase -> haddr/htrans held, no gnt, done at N+3.
- Default-satellite address (ERROR), with ch1 requesting in the first error cycle:
  - First error cycle: htrans=IDLE, no gnt.
  - Second error cycle: done[0] with err=1 and gnt[1].
- Half-word at 0x5 and word at 0x6 -> gnt, then next-cycle done+err; no NONSEQ on the bus.
